// File: rtl/spi_shift_ctrl_if.sv
// Signal bundle between the SPI register slave / serial pins and the
// spi_shift_ctrl transfer engine. The engine uses the master modport.
interface spi_shift_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              mstr_i;
   logic              cpol_i;
   logic              cpha_i;
   logic              lsbfe_i;
   logic [2:0]        sppr_i;
   logic [2:0]        spr_i;
   logic              send_data_i;
   logic [DATA_W-1:0] mosi_data_i;
   logic              miso_i;
   logic              sclk_o;
   logic              ss_o;
   logic              mosi_o;
   logic              tip_o;
   logic              receive_data_o;
   logic [DATA_W-1:0] miso_data_o;

   modport master (
      input  mstr_i, cpol_i, cpha_i, lsbfe_i, sppr_i, spr_i,
      input  send_data_i, mosi_data_i, miso_i,
      output sclk_o, ss_o, mosi_o, tip_o, receive_data_o, miso_data_o
   );

   modport slave (
      output mstr_i, cpol_i, cpha_i, lsbfe_i, sppr_i, spr_i,
      output send_data_i, mosi_data_i, miso_i,
      input  sclk_o, ss_o, mosi_o, tip_o, receive_data_o, miso_data_o
   );
endinterface

// File: rtl/spi_shift_ctrl.sv
// SPI master shift engine with baud divider: one byte per send_data request.
// Optional macro SPI_LOOPBACK_EN samples mosi_o instead of miso_i.
module spi_shift_ctrl #(
   parameter int DATA_W = 8
) (
   input  logic             PCLK,
   input  logic             PRESET,
   spi_shift_ctrl_if.master bus
);
   localparam int EDGES = 2 * DATA_W;
   localparam int EW    = $clog2(EDGES);
   localparam int BW    = $clog2(DATA_W);
   localparam logic [BW-1:0] MSB_IDX   = BW'(DATA_W - 1);
   localparam logic [EW-1:0] LAST_EDGE = EW'(EDGES - 1);

   typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;

   state_t            state;
   logic [10:0]       div_cnt;
   logic [10:0]       half_m1;
   logic              tick;
   logic [EW-1:0]     edge_cnt;
   logic              cpol_q;
   logic              cpha_q;
   logic              lsbfe_q;
   logic [2:0]        sppr_q;
   logic [2:0]        spr_q;
   logic [DATA_W-1:0] tx_byte;
   logic [DATA_W-1:0] rx_byte;
   logic              serial_in;
   logic              accept;
   logic              do_sample;
   logic              do_shift;
   logic [BW-1:0]     bit_k;
   logic [BW-1:0]     shift_k;

   function automatic logic [10:0] half_period_m1(input logic [2:0] sppr,
                                                  input logic [2:0] spr);
      logic [10:0] h;
      h = ({8'd0, sppr} + 11'd1) << spr;
      return h - 11'd1;
   endfunction

   function automatic logic pick_bit(input logic [DATA_W-1:0] b,
                                     input logic lsbf,
                                     input logic [BW-1:0] k);
      return lsbf ? b[k] : b[MSB_IDX - k];
   endfunction

   function automatic logic [DATA_W-1:0] place_bit(input logic [DATA_W-1:0] b,
                                                   input logic lsbf,
                                                   input logic [BW-1:0] k,
                                                   input logic v);
      logic [DATA_W-1:0] r;
      r = b;
      if (lsbf)
         r[k] = v;
      else
         r[MSB_IDX - k] = v;
      return r;
   endfunction

`ifdef SPI_LOOPBACK_EN
   assign serial_in = bus.mosi_o;
`else
   assign serial_in = bus.miso_i;
`endif

   assign half_m1 = half_period_m1(sppr_q, spr_q);
   assign tick    = (div_cnt == half_m1);
   assign accept  = (state == IDLE) && bus.send_data_i && bus.mstr_i;

   // Even 0-based edge index is a leading edge; each bit owns one edge pair.
   assign bit_k     = edge_cnt[EW-1:1];
   assign shift_k   = cpha_q ? bit_k : bit_k + BW'(1);
   assign do_sample = (state == XFER) && tick && (edge_cnt[0] == cpha_q);
   assign do_shift  = (state == XFER) && tick && (edge_cnt[0] != cpha_q) &&
                      (cpha_q || (edge_cnt != LAST_EDGE));

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state              <= IDLE;
         div_cnt            <= '0;
         edge_cnt           <= '0;
         cpol_q             <= 1'b0;
         cpha_q             <= 1'b0;
         lsbfe_q            <= 1'b0;
         sppr_q             <= '0;
         spr_q              <= '0;
         bus.sclk_o         <= 1'b0;
         bus.ss_o           <= 1'b1;
         bus.mosi_o         <= 1'b0;
         bus.tip_o          <= 1'b0;
         bus.receive_data_o <= 1'b0;
         bus.miso_data_o    <= '0;
      end else begin
         bus.receive_data_o <= 1'b0;
         case (state)
            IDLE: begin
               bus.sclk_o <= bus.cpol_i;
               bus.ss_o   <= 1'b1;
               bus.tip_o  <= 1'b0;
               bus.mosi_o <= 1'b0;
               div_cnt    <= '0;
               edge_cnt   <= '0;
               if (accept) begin
                  cpol_q    <= bus.cpol_i;
                  cpha_q    <= bus.cpha_i;
                  lsbfe_q   <= bus.lsbfe_i;
                  sppr_q    <= bus.sppr_i;
                  spr_q     <= bus.spr_i;
                  bus.ss_o  <= 1'b0;
                  bus.tip_o <= 1'b1;
                  if (!bus.cpha_i)
                     bus.mosi_o <= pick_bit(bus.mosi_data_i, bus.lsbfe_i, '0);
                  state <= LEAD;
               end
            end
            LEAD: begin
               div_cnt <= tick ? '0 : div_cnt + 11'd1;
               if (tick)
                  state <= XFER;
            end
            XFER: begin
               div_cnt <= tick ? '0 : div_cnt + 11'd1;
               if (tick) begin
                  bus.sclk_o <= ~bus.sclk_o;
                  edge_cnt   <= edge_cnt + EW'(1);
                  if (do_shift)
                     bus.mosi_o <= pick_bit(tx_byte, lsbfe_q, shift_k);
                  if (edge_cnt == LAST_EDGE) begin
                     edge_cnt <= '0;
                     state    <= TRAIL;
                  end
               end
            end
            TRAIL: begin
               div_cnt <= tick ? '0 : div_cnt + 11'd1;
               if (tick) begin
                  bus.ss_o           <= 1'b1;
                  bus.tip_o          <= 1'b0;
                  bus.mosi_o         <= 1'b0;
                  bus.receive_data_o <= 1'b1;
                  bus.miso_data_o    <= rx_byte;
                  state              <= DONE;
               end
            end
            DONE: begin
               div_cnt <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Shift data carries no reset: it is reloaded on every accepted request.
   always_ff @(posedge PCLK) begin
      if (accept) begin
         tx_byte <= bus.mosi_data_i;
         rx_byte <= '0;
      end else if (do_sample) begin
         rx_byte <= place_bit(rx_byte, lsbfe_q, bit_k, serial_in);
      end
   end
endmodule

// File: tb/tb_spi_shift_ctrl.sv
// Directed bench for spi_shift_ctrl: modes 0/1/3, divider extremes, busy
// rejection, reset abort and loopback-dependent receive expectations.
`timescale 1ns/1ps
module tb_spi_shift_ctrl;
   logic PCLK;
   logic PRESET;
   int   n_vec;
   int   n_err;

   spi_shift_ctrl_if bus ();

   spi_shift_ctrl dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .bus    (bus)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one transfer starting in an IDLE cycle; miso follows rxpat in
   // transmit order, changing on the trailing-edge side of each sample.
   task automatic run_xfer(input string tag, input logic [7:0] tx, input logic [7:0] rxpat,
                           input logic cpol, input logic cpha, input logic lsbf,
                           input logic [2:0] sppr, input logic [2:0] spr, input int busy_c);
      int h, k, off, tip_cnt, npulse, rcv_c, first_tog;
      logic [7:0] exp_rx;
      h = (int'(sppr) + 1) << spr;
`ifdef SPI_LOOPBACK_EN
      exp_rx = tx;
`else
      exp_rx = rxpat;
`endif
      tip_cnt = 0; npulse = 0; rcv_c = 0; first_tog = 0;
      bus.cpol_i = cpol; bus.cpha_i = cpha; bus.lsbfe_i = lsbf;
      bus.sppr_i = sppr; bus.spr_i = spr; bus.mstr_i = 1'b1;
      bus.mosi_data_i = tx; bus.send_data_i = 1'b1;
      bus.miso_i = lsbf ? rxpat[0] : rxpat[7];
      step();
      bus.send_data_i = 1'b0;
      bus.mosi_data_i = ~tx;
      bus.sppr_i = ~sppr;
      for (int c = 1; c <= 18 * h + 1; c++) begin
         off = c - 1 - (cpha ? h : 0);
         k = (off < 0) ? 0 : off / (2 * h);
         if (k > 7) k = 7;
         bus.miso_i = lsbf ? rxpat[k] : rxpat[7 - k];
         if (busy_c != 0 && c == busy_c) begin
            bus.send_data_i = 1'b1; bus.mosi_data_i = 8'hFF;
            bus.mstr_i = 1'b0; bus.lsbfe_i = ~lsbf; bus.cpha_i = ~cpha;
         end
         if (busy_c != 0 && c == busy_c + 1) begin
            bus.send_data_i = 1'b0; bus.mstr_i = 1'b1;
            bus.lsbfe_i = lsbf; bus.cpha_i = cpha;
         end
         if (c == (2 * k + 2 + (cpha ? 1 : 0)) * h)
            check({tag, "/mosi"}, 32'(bus.mosi_o), 32'(lsbf ? tx[k] : tx[7 - k]));
         tip_cnt += int'(bus.tip_o);
         if (bus.receive_data_o) begin
            npulse++;
            rcv_c = c;
         end
         if (first_tog == 0 && bus.sclk_o !== cpol) first_tog = c;
         step();
      end
      bus.sppr_i = sppr;
      check({tag, "/tip_cycles"}, 32'(tip_cnt), 32'(18 * h));
      check({tag, "/rcv_cycle"}, 32'(rcv_c), 32'(18 * h + 1));
      check({tag, "/rcv_pulses"}, 32'(npulse), 32'd1);
      check({tag, "/first_sclk_toggle"}, 32'(first_tog), 32'(2 * h + 1));
      check({tag, "/miso_data"}, 32'(bus.miso_data_o), 32'(exp_rx));
      check({tag, "/ss_after"}, 32'(bus.ss_o), 32'd1);
      check({tag, "/tip_after"}, 32'(bus.tip_o), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "/sclk"}, 32'(bus.sclk_o), 32'd0);
      check({tag, "/ss"}, 32'(bus.ss_o), 32'd1);
      check({tag, "/mosi"}, 32'(bus.mosi_o), 32'd0);
      check({tag, "/tip"}, 32'(bus.tip_o), 32'd0);
      check({tag, "/rcv"}, 32'(bus.receive_data_o), 32'd0);
      check({tag, "/miso_data"}, 32'(bus.miso_data_o), 32'd0);
   endtask

   initial begin
      int npulse, ntip;
      n_vec = 0; n_err = 0;
      PRESET = 1'b1;
      bus.mstr_i = 1'b0; bus.cpol_i = 1'b0; bus.cpha_i = 1'b0; bus.lsbfe_i = 1'b0;
      bus.sppr_i = 3'd0; bus.spr_i = 3'd0; bus.send_data_i = 1'b0;
      bus.mosi_data_i = 8'h00; bus.miso_i = 1'b0;
      step();
      step();
      check_reset_outputs("reset");
      PRESET = 1'b0;
      step();

      run_xfer("mode0", 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 0);
      run_xfer("mode3", 8'h81, 8'hF0, 1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 0);
      step();
      check("mode3/sclk_idle", 32'(bus.sclk_o), 32'd1);

      // Abort after XFER edge 7 with a non-zero received byte on record.
      bus.cpol_i = 1'b0; bus.cpha_i = 1'b0; bus.lsbfe_i = 1'b0;
      bus.sppr_i = 3'd0; bus.spr_i = 3'd0; bus.mstr_i = 1'b1;
      bus.mosi_data_i = 8'hC3; bus.send_data_i = 1'b1;
      step();
      bus.send_data_i = 1'b0;
      repeat (8) step();
      check("rst_mid/sclk_before", 32'(bus.sclk_o), 32'd1);
      check("rst_mid/tip_before", 32'(bus.tip_o), 32'd1);
      PRESET = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      step();
      PRESET = 1'b0;
      npulse = 0; ntip = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         npulse += int'(bus.receive_data_o);
         ntip += int'(bus.tip_o);
      end
      check("rst_mid/no_rcv", 32'(npulse), 32'd0);
      check("rst_mid/no_tip", 32'(ntip), 32'd0);
      check("rst_mid/miso_data", 32'(bus.miso_data_o), 32'd0);

      run_xfer("busy", 8'h55, 8'h0F, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 6);

      bus.mstr_i = 1'b0; bus.mosi_data_i = 8'h99; bus.send_data_i = 1'b1;
      step();
      bus.send_data_i = 1'b0;
      check("mstr0/ss", 32'(bus.ss_o), 32'd1);
      check("mstr0/tip", 32'(bus.tip_o), 32'd0);
      step();
      check("mstr0/ss_later", 32'(bus.ss_o), 32'd1);
      check("mstr0/tip_later", 32'(bus.tip_o), 32'd0);
      check("mstr0/miso_data_held", 32'(bus.miso_data_o), 32'h0F);

      run_xfer("loop", 8'h6B, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 0);
      run_xfer("div_max", 8'h96, 8'h5A, 1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
